// File: rtl/intr_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : intr_sequencer                                                |
// | Purpose  : Latches edge requests, masks, resolves nested priority and    |
// |            runs the two-pulse INTA handshake returning a vector.         |
// |            Define INTR_ROTATING_PRIORITY_EN for rotating priority.       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module intr_sequencer #(
   parameter int               NUM_IRQ     = 8,
   parameter int               VEC_W       = 8,
   parameter logic [VEC_W-1:0] VECTOR_BASE = 8'h08
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               imr_wr,
   input  logic [NUM_IRQ-1:0] imr_data,
   input  logic               eoi,
   input  logic               inta,
   output logic               int_out,
   output logic [VEC_W-1:0]   vector_out,
   output logic               vector_valid,
   output logic [NUM_IRQ-1:0] irr_out,
   output logic [NUM_IRQ-1:0] isr_out,
   output logic [NUM_IRQ-1:0] imr_out
);

   localparam int                 c_idx_w    = $clog2(NUM_IRQ);
   localparam logic [c_idx_w:0]   c_num_irq  = NUM_IRQ[c_idx_w:0];
   localparam logic [c_idx_w-1:0] c_spur_idx = c_idx_w'(NUM_IRQ - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_ACK1 = 2'd2
   } state_t;

   // Line index holding priority rank 'rank' when 'ptr' is the top line.
   function automatic logic [c_idx_w-1:0] rot_idx(input logic [c_idx_w-1:0] ptr,
                                                  input logic [c_idx_w-1:0] rank);
      logic [c_idx_w:0] sum;
      sum = {1'b0, ptr} + {1'b0, rank};
      if (sum >= c_num_irq) sum = sum - c_num_irq;
      return sum[c_idx_w-1:0];
   endfunction

   // Returns {found, rank} of the highest-priority set bit.
   function automatic logic [c_idx_w:0] top_rank(input logic [NUM_IRQ-1:0] vec,
                                                 input logic [c_idx_w-1:0] ptr);
      logic [c_idx_w:0] res;
      res = '0;
      for (int k = NUM_IRQ - 1; k >= 0; k--) begin
         if (vec[rot_idx(ptr, k[c_idx_w-1:0])]) res = {1'b1, k[c_idx_w-1:0]};
      end
      return res;
   endfunction

   state_t               r_state, w_state_nxt;
   logic [NUM_IRQ-1:0]   r_irr, r_isr, r_imr, r_irq_q;
   logic                 r_inta_q, r_int_out, r_vvalid;
   logic [VEC_W-1:0]     r_vector;
   logic [c_idx_w-1:0]   r_idx;

   logic [NUM_IRQ-1:0]   w_irr_nxt, w_isr_nxt, w_isr_eoi;
   logic                 w_int_nxt, w_vvalid_nxt, w_inta_rise;
   logic [VEC_W-1:0]     w_vec_nxt;
   logic [c_idx_w-1:0]   w_idx_nxt, w_ptr_cur, w_ptr_eoi, w_eoi_idx, w_win_idx;
   logic [c_idx_w:0]     w_eoi_top, w_win_top, w_isr_top;
   logic                 w_win_valid;

   assign w_inta_rise = inta & ~r_inta_q;

   // EOI is folded in before resolution so a same-edge grant sees the freed slot.
   assign w_eoi_top = top_rank(r_isr, w_ptr_cur);
   assign w_eoi_idx = rot_idx(w_ptr_cur, w_eoi_top[c_idx_w-1:0]);

   always_comb begin
      w_isr_eoi = r_isr;
      if (eoi && w_eoi_top[c_idx_w]) w_isr_eoi[w_eoi_idx] = 1'b0;
   end

`ifdef INTR_ROTATING_PRIORITY_EN
   logic [c_idx_w-1:0] r_ptr;

   assign w_ptr_cur = r_ptr;
   assign w_ptr_eoi = (eoi && w_eoi_top[c_idx_w]) ? rot_idx(w_eoi_idx, c_idx_w'(1)) : r_ptr;

   always_ff @(posedge clk) begin
      if (rst) r_ptr <= '0;
      else     r_ptr <= w_ptr_eoi;
   end
`else
   assign w_ptr_cur = '0;
   assign w_ptr_eoi = '0;
`endif

   assign w_win_top   = top_rank(r_irr & ~r_imr, w_ptr_eoi);
   assign w_isr_top   = top_rank(w_isr_eoi, w_ptr_eoi);
   assign w_win_idx   = rot_idx(w_ptr_eoi, w_win_top[c_idx_w-1:0]);
   assign w_win_valid = w_win_top[c_idx_w] &&
                        (!w_isr_top[c_idx_w] ||
                         (w_win_top[c_idx_w-1:0] < w_isr_top[c_idx_w-1:0]));

   always_comb begin
      w_state_nxt  = r_state;
      w_irr_nxt    = r_irr | (irq_in & ~r_irq_q);
      w_isr_nxt    = w_isr_eoi;
      w_idx_nxt    = r_idx;
      w_int_nxt    = r_int_out;
      w_vec_nxt    = r_vector;
      w_vvalid_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_win_valid) begin
               w_state_nxt = S_REQ;
               w_int_nxt   = 1'b1;
            end
         end
         S_REQ: begin
            if (w_inta_rise) begin
               w_state_nxt = S_ACK1;
               w_int_nxt   = 1'b0;
               if (w_win_valid) begin
                  w_isr_nxt[w_win_idx] = 1'b1;
                  w_irr_nxt[w_win_idx] = 1'b0;
                  w_idx_nxt            = w_win_idx;
               end else begin
                  w_idx_nxt = c_spur_idx;
               end
            end
         end
         S_ACK1: begin
            if (w_inta_rise) begin
               w_state_nxt  = S_IDLE;
               w_vec_nxt    = VECTOR_BASE + VEC_W'(r_idx);
               w_vvalid_nxt = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_irr     <= '0;
         r_isr     <= '0;
         r_imr     <= '0;
         r_irq_q   <= '0;
         r_inta_q  <= 1'b0;
         r_int_out <= 1'b0;
         r_vector  <= '0;
         r_vvalid  <= 1'b0;
         r_idx     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_irr     <= w_irr_nxt;
         r_isr     <= w_isr_nxt;
         r_imr     <= imr_wr ? imr_data : r_imr;
         r_irq_q   <= irq_in;
         r_inta_q  <= inta;
         r_int_out <= w_int_nxt;
         r_vector  <= w_vec_nxt;
         r_vvalid  <= w_vvalid_nxt;
         r_idx     <= w_idx_nxt;
      end
   end

   assign int_out      = r_int_out;
   assign vector_out   = r_vector;
   assign vector_valid = r_vvalid;
   assign irr_out      = r_irr;
   assign isr_out      = r_isr;
   assign imr_out      = r_imr;

endmodule
`default_nettype wire

// File: tb/tb_intr_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_intr_sequencer                                             |
// | Purpose  : Directed self-checking bench for intr_sequencer.              |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_intr_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] irq_in, imr_data;
   logic       imr_wr, eoi, inta;
   logic       int_out, vector_valid;
   logic [7:0] vector_out, irr_out, isr_out, imr_out;

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   intr_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .irq_in       (irq_in),
      .imr_wr       (imr_wr),
      .imr_data     (imr_data),
      .eoi          (eoi),
      .inta         (inta),
      .int_out      (int_out),
      .vector_out   (vector_out),
      .vector_valid (vector_valid),
      .irr_out      (irr_out),
      .isr_out      (isr_out),
      .imr_out      (imr_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic pulse_irq(input logic [7:0] m);
      irq_in = m;
      cyc();
      irq_in = '0;
   endtask

   task automatic ack();
      inta = 1'b1;
      cyc();
      inta = 1'b0;
   endtask

   task automatic eoi_pulse();
      eoi = 1'b1;
      cyc();
      eoi = 1'b0;
   endtask

   task automatic imr_write(input logic [7:0] m);
      imr_wr   = 1'b1;
      imr_data = m;
      cyc();
      imr_wr   = 1'b0;
   endtask

   initial begin
      rst = 1'b1; irq_in = '0; imr_data = '0; imr_wr = 1'b0; eoi = 1'b0; inta = 1'b0;
      cyc(); cyc();
      chk("rst_int", int_out, 0);
      chk("rst_vec", vector_out, 0);
      chk("rst_vv", vector_valid, 0);
      chk("rst_irr", irr_out, 0);
      chk("rst_isr", isr_out, 0);
      chk("rst_imr", imr_out, 0);
      rst = 1'b0;

      // single request on line 3
      pulse_irq(8'h08);
      chk("t1_irr", irr_out, 8'h08);
      chk("t1_int_lat", int_out, 0);
      cyc();
      chk("t1_int", int_out, 1);
      ack();
      chk("t1_ack1_int", int_out, 0);
      chk("t1_ack1_isr", isr_out, 8'h08);
      chk("t1_ack1_irr", irr_out, 8'h00);
      chk("t1_ack1_vv", vector_valid, 0);
      cyc();
      ack();
      chk("t1_vec", vector_out, 8'h0B);
      chk("t1_vv", vector_valid, 1);
      cyc();
      chk("t1_vv_low", vector_valid, 0);
      chk("t1_vec_hold", vector_out, 8'h0B);
      eoi_pulse();
      chk("t1_eoi_isr", isr_out, 8'h00);

      // simultaneous lines 5 and 2
      pulse_irq(8'h24);
      cyc();
      chk("t2_int", int_out, 1);
      ack();
      chk("t2_isr", isr_out, 8'h04);
      chk("t2_irr", irr_out, 8'h20);
      cyc();
      ack();
      chk("t2_vec_a", vector_out, 8'h0A);
      cyc(); cyc();
      chk("t2_blocked", int_out, 0);
      eoi_pulse();
      chk("t2_eoi_isr", isr_out, 8'h00);
      cyc();
      chk("t2_int_b", int_out, 1);
      ack();
      chk("t2_isr_b", isr_out, 8'h20);
      cyc();
      ack();
      chk("t2_vec_b", vector_out, 8'h0D);
      eoi_pulse();

      // mask
      imr_write(8'h04);
      chk("t3_imr", imr_out, 8'h04);
      pulse_irq(8'h04);
      chk("t3_irr", irr_out, 8'h04);
      cyc(); cyc();
      chk("t3_masked", int_out, 0);
      imr_write(8'h00);
      chk("t3_unmask_0", int_out, 0);
      cyc();
      chk("t3_unmask_1", int_out, 1);
      ack(); cyc(); ack();
      chk("t3_vec", vector_out, 8'h0A);
      eoi_pulse();

      // nesting
      pulse_irq(8'h10);
      cyc();
      chk("t4_int", int_out, 1);
      ack(); cyc(); ack();
      chk("t4_vec4", vector_out, 8'h0C);
      chk("t4_isr4", isr_out, 8'h10);
      pulse_irq(8'h40);
      chk("t4_irr6", irr_out, 8'h40);
      cyc(); cyc();
      chk("t4_low_blocked", int_out, 0);
      pulse_irq(8'h02);
      cyc();
      chk("t4_int1", int_out, 1);
      ack();
      chk("t4_isr12", isr_out, 8'h12);
      chk("t4_irr40", irr_out, 8'h40);
      cyc();
      ack();
      chk("t4_vec1", vector_out, 8'h09);
      eoi_pulse();
      chk("t4_eoi1", isr_out, 8'h10);
      eoi_pulse();
      chk("t4_eoi2", isr_out, 8'h00);
      cyc();
      chk("t4_int6", int_out, 1);
      ack(); cyc(); ack();
      chk("t4_vec6", vector_out, 8'h0E);
      eoi_pulse();

      // spurious, then reset mid-handshake
      pulse_irq(8'h01);
      cyc();
      chk("t5_int", int_out, 1);
      imr_write(8'h01);
      chk("t5_req_held", int_out, 1);
      ack();
      chk("t5_spur_isr", isr_out, 8'h00);
      chk("t5_spur_irr", irr_out, 8'h01);
      chk("t5_spur_int", int_out, 0);
      cyc();
      ack();
      chk("t5_spur_vec", vector_out, 8'h0F);
      chk("t5_spur_vv", vector_valid, 1);
      cyc();
      imr_write(8'h00);
      cyc();
      chk("t5_int0", int_out, 1);
      ack();
      chk("t5_isr0", isr_out, 8'h01);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("t5_rst_int", int_out, 0);
      chk("t5_rst_vec", vector_out, 0);
      chk("t5_rst_vv", vector_valid, 0);
      chk("t5_rst_irr", irr_out, 0);
      chk("t5_rst_isr", isr_out, 0);
      chk("t5_rst_imr", imr_out, 0);
      ack(); cyc(); ack();
      chk("t5_ign_vv", vector_valid, 0);
      chk("t5_ign_vec", vector_out, 0);
      chk("t5_ign_isr", isr_out, 0);
      cyc();
      chk("t5_ign_int", int_out, 0);

`ifdef INTR_ROTATING_PRIORITY_EN
      // rotating priority
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      pulse_irq(8'h03);
      cyc();
      ack();
      chk("t6_isr0", isr_out, 8'h01);
      cyc();
      ack();
      chk("t6_vec0", vector_out, 8'h08);
      eoi_pulse();
      cyc();
      chk("t6_int1", int_out, 1);
      ack();
      chk("t6_isr1", isr_out, 8'h02);
      cyc();
      ack();
      chk("t6_vec1", vector_out, 8'h09);
      eoi_pulse();
      pulse_irq(8'h81);
      cyc();
      ack();
      chk("t6_isr7", isr_out, 8'h80);
      chk("t6_irr0", irr_out, 8'h01);
      cyc();
      ack();
      chk("t6_vec7", vector_out, 8'h0F);
      eoi_pulse();
      cyc();
      ack();
      chk("t6_isr0b", isr_out, 8'h01);
      cyc();
      ack();
      chk("t6_vec0b", vector_out, 8'h08);
      eoi_pulse();
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/intr_sequencer.md
# intr_sequencer

Parametrised interrupt request sequencer: latches up to NUM_IRQ edge-triggered requests, applies a mask, resolves priority against the in-service set, raises `int_out` and runs the two-pulse acknowledge handshake that returns an interrupt vector. Fully synchronous successor to the combinational control/priority glue. Sits between peripheral request lines and the CPU interrupt pin and data bus.

## Interface
- `NUM_IRQ`, 8: number of request lines, 2..32.
- `VEC_W`, 8: vector width.
- `VECTOR_BASE`, 8'h08: vector for line 0; line i returns `VECTOR_BASE + i`.

- `clk`  in  1  sole clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `irq_in`  in  NUM_IRQ  request lines; rising edge (sampled) latches request.
- `imr_wr`  in  1  load mask register from `imr_data` this edge.
- `imr_data`  in  NUM_IRQ  new mask; 1 = line masked.
- `eoi`  in  1  one-cycle non-specific end-of-interrupt.
- `inta`  in  1  CPU acknowledge, active-high, synchronous; rising edges counted.
- `int_out`  out  1  interrupt request to CPU, registered.
- `vector_out`  out  VEC_W  acknowledged vector, held until next ACK2.
- `vector_valid`  out  1  one-cycle strobe with new `vector_out`.
- `irr_out`, `isr_out`, `imr_out`  out  NUM_IRQ  register visibility.

## Operation
- Reset: IRR, ISR, IMR, `irq_q`, `inta_q` = 0; `int_out`=0, `vector_out`=0, `vector_valid`=0; state IDLE; rotation pointer = 0.
- IRR bit i sets when `irq_in[i] & ~irq_q[i]`; cleared only when granted at ACK1. Masked lines still latch; they are ineligible while masked.
- Eligible = IRR & ~IMR. Winner = highest-priority eligible bit; valid only if its priority is strictly higher than highest ISR bit (nesting).
- Fixed priority: index 0 highest.
- States: IDLE -> REQ when winner valid (`int_out`<=1). REQ -> ACK1 on `inta` rise: re-resolve winner, set its ISR bit, clear its IRR bit, latch index, `int_out`<=0. ACK1 -> IDLE on second `inta` rise: `vector_out`<=VECTOR_BASE+index (mod 2^VEC_W), `vector_valid`<=1.
- Spurious: no valid winner at ACK1 -> latch index NUM_IRQ-1, ISR/IRR untouched.
- `inta` rises in IDLE ignored. REQ persists if requests vanish; resolved as spurious.
- EOI clears highest-priority ISR bit; no ISR bits -> no effect. EOI same edge as ACK1: EOI applied first, then grant evaluated on updated ISR.
- `imr_wr` takes effect for resolution on following cycle.
- `rst` in any state returns to reset values next edge; half-done handshake abandoned.

## Timing
- `irq_in` first sampled high at edge k: IRR bit set after k; `int_out` high after k+1 (if eligible).
- `inta` first sampled high at edge m (ACK1): ISR/IRR update and `int_out` low after m.
- Second `inta` rise at edge n: `vector_out`, `vector_valid` after n; `vector_valid` low after n+1.
- `inta` must be low at least one cycle between pulses; single high level counts once.
- Index width `$clog2(NUM_IRQ)`; vector sum truncated to VEC_W.

## Configuration
- `INTR_ROTATING_PRIORITY_EN` defined: rotating priority; on EOI the cleared line becomes lowest, pointer = cleared index + 1 (mod NUM_IRQ) is highest; nesting comparison uses rotated order.
- Undefined: fixed priority, pointer logic absent, EOI only clears ISR.

## Test plan
- Single request: pulse `irq_in[3]`, two `inta` pulses -> `int_out` 1 then 0 after ACK1, `vector_out`=8'h0B, `isr_out`=8'h08, `irr_out`=0.
- Simultaneous `irq_in[5]`,`irq_in[2]` -> first vector 8'h0A; after EOI and second handshake 8'h0D.
- Mask: IMR=8'h04, raise line 2 -> `int_out` stays 0; IMR=0 -> `int_out` high two cycles later.
- Nesting: line 4 in service, raise line 6 -> no `int_out`; raise line 1 -> `int_out`, vector 8'h09, `isr_out`=8'h12.
- Spurious + reset: raise line 0 and mask it before ACK1 -> vector 8'h0F, ISR unchanged; assert `rst` after ACK1 -> all outputs 0, next `inta` ignored.
- With macro: lines 0 and 1 pending, service line 0 + EOI -> line 1 next; re-raise 0 with 7 pending -> 7 wins before 0.
